// File: rtl/spi_cmd_ctrl.sv
// rtl/spi_cmd_ctrl.sv - SPI command frame to 16-bit register/VRAM bus bridge
// Frame: CMD, ADDR_H, ADDR_L, then 16-bit data words MSB byte first.
module spi_cmd_ctrl #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_RX_DV,
  input  logic [7:0]  i_RX_Byte,
  output logic        o_TX_DV,
  output logic [7:0]  o_TX_Byte,
  input  logic        i_SPI_CS_n,
  output logic [15:0] o_Bus_Addr,
  output logic [15:0] o_Bus_WData,
  output logic        o_Bus_Wr,
  output logic        o_Bus_Rd,
  input  logic [15:0] i_Bus_RData,
  input  logic        i_Bus_Ack,
  output logic        o_Err,
  output logic        o_Busy
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(ACK_TIMEOUT - 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_CMD     = 4'd1;
  localparam logic [3:0] S_ADDR_H  = 4'd2;
  localparam logic [3:0] S_ADDR_L  = 4'd3;
  localparam logic [3:0] S_WR_H    = 4'd4;
  localparam logic [3:0] S_WR_L    = 4'd5;
  localparam logic [3:0] S_BUS_WR  = 4'd6;
  localparam logic [3:0] S_RD_REQ  = 4'd7;
  localparam logic [3:0] S_TX_H    = 4'd8;
  localparam logic [3:0] S_TX_L    = 4'd9;
  localparam logic [3:0] S_DISCARD = 4'd10;

  logic          cs_meta_q, cs_sync_q, cs_prev_q;
  logic [3:0]    state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [7:0]    rdata_lo_q, rdata_lo_d;
  logic          auto_inc_q, auto_inc_d;
  logic          rd_mode_q, rd_mode_d;
  logic          tx_dv_q, tx_dv_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          wr_q, wr_d;
  logic          rd_q, rd_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          end_pend_q, end_pend_d;

  logic        frame_start, frame_end, bus_state, timed_out, bus_done, ending;
  logic [15:0] addr_inc;

  assign frame_start = cs_prev_q & ~cs_sync_q;
  assign frame_end   = ~cs_prev_q & cs_sync_q;
  assign bus_state   = (state_q == S_BUS_WR) || (state_q == S_RD_REQ);
  assign timed_out   = bus_state && !i_Bus_Ack && (cnt_q == TMO_LAST);
  assign bus_done    = bus_state && (i_Bus_Ack || timed_out);
  // A frame that ends mid-access still completes the access, then stops silently.
  assign ending      = end_pend_q || frame_end;
  assign addr_inc    = addr_q + (auto_inc_q ? 16'd1 : 16'd0);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_lo_d = rdata_lo_q;
    auto_inc_d = auto_inc_q;
    rd_mode_d  = rd_mode_q;
    tx_dv_d    = 1'b0;
    tx_byte_d  = tx_byte_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    end_pend_d = end_pend_q;

    if (frame_end && !bus_state && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (frame_start) begin
          state_d    = S_CMD;
          err_d      = 1'b0;
          end_pend_d = 1'b0;
          tx_dv_d    = 1'b1;
          tx_byte_d  = 8'hA5;
        end
        S_CMD: if (i_RX_DV) begin
          if (i_RX_Byte[5:0] != 6'd0) begin
            err_d   = 1'b1;
            state_d = S_DISCARD;
          end else begin
            rd_mode_d  = i_RX_Byte[7];
            auto_inc_d = i_RX_Byte[6];
            state_d    = S_ADDR_H;
          end
        end
        S_ADDR_H: if (i_RX_DV) begin
          addr_d[15:8] = i_RX_Byte;
          state_d      = S_ADDR_L;
        end
        S_ADDR_L: if (i_RX_DV) begin
          addr_d[7:0] = i_RX_Byte;
          if (rd_mode_q) begin
            state_d = S_RD_REQ;
            rd_d    = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = S_WR_H;
          end
        end
        S_WR_H: if (i_RX_DV) begin
          wdata_d[15:8] = i_RX_Byte;
          state_d       = S_WR_L;
        end
        S_WR_L: if (i_RX_DV) begin
          wdata_d[7:0] = i_RX_Byte;
          state_d      = S_BUS_WR;
          wr_d         = 1'b1;
          cnt_d        = '0;
        end
        S_BUS_WR: begin
          if (frame_end) end_pend_d = 1'b1;
          if (bus_done) begin
            wr_d   = 1'b0;
            addr_d = addr_inc;
            if (timed_out) err_d = 1'b1;
            if (ending) begin
              state_d = S_IDLE;
            end else if (i_Bus_Ack && i_RX_DV) begin
              err_d   = 1'b1;
              state_d = S_DISCARD;
            end else begin
              state_d = S_WR_H;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_RD_REQ: begin
          if (frame_end) end_pend_d = 1'b1;
          if (bus_done) begin
            rd_d = 1'b0;
            if (timed_out) err_d = 1'b1;
            if (ending) begin
              state_d = S_IDLE;
            end else if (i_Bus_Ack && i_RX_DV) begin
              err_d   = 1'b1;
              state_d = S_DISCARD;
            end else begin
              rdata_lo_d = timed_out ? 8'hFF : i_Bus_RData[7:0];
              tx_byte_d  = timed_out ? 8'hFF : i_Bus_RData[15:8];
              tx_dv_d    = 1'b1;
              state_d    = S_TX_H;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_TX_H: if (i_RX_DV) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = rdata_lo_q;
          state_d   = S_TX_L;
        end
        S_TX_L: if (i_RX_DV) begin
          addr_d  = addr_inc;
          state_d = S_RD_REQ;
          rd_d    = 1'b1;
          cnt_d   = '0;
        end
        S_DISCARD: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cs_meta_q  <= 1'b1;
      cs_sync_q  <= 1'b1;
      cs_prev_q  <= 1'b1;
      state_q    <= S_IDLE;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      rdata_lo_q <= 8'h00;
      auto_inc_q <= 1'b0;
      rd_mode_q  <= 1'b0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= 8'h00;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      end_pend_q <= 1'b0;
    end else begin
      cs_meta_q  <= i_SPI_CS_n;
      cs_sync_q  <= cs_meta_q;
      cs_prev_q  <= cs_sync_q;
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_lo_q <= rdata_lo_d;
      auto_inc_q <= auto_inc_d;
      rd_mode_q  <= rd_mode_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      end_pend_q <= end_pend_d;
    end
  end

  assign o_TX_DV     = tx_dv_q;
  assign o_TX_Byte   = tx_byte_q;
  assign o_Bus_Addr  = addr_q;
  assign o_Bus_WData = wdata_q;
  assign o_Bus_Wr    = wr_q;
  assign o_Bus_Rd    = rd_q;
  assign o_Err       = err_q;
  assign o_Busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb/tb_spi_cmd_ctrl.sv - directed self-checking bench for spi_cmd_ctrl
`timescale 1ns/1ps
module tb_spi_cmd_ctrl;
  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        cs_n;
  logic [15:0] bus_rdata = 16'h0;
  logic        bus_ack = 1'b0;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic [15:0] bus_addr, bus_wdata;
  logic        bus_wr, bus_rd, err, busy;

  spi_cmd_ctrl #(.ACK_TIMEOUT(TMO)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
    .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte), .i_SPI_CS_n(cs_n),
    .o_Bus_Addr(bus_addr), .o_Bus_WData(bus_wdata), .o_Bus_Wr(bus_wr),
    .o_Bus_Rd(bus_rd), .i_Bus_RData(bus_rdata), .i_Bus_Ack(bus_ack),
    .o_Err(err), .o_Busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // bus slave model and activity log; ack_delay 0 means never acknowledge
  int          ack_delay = 3;
  int          strobe_cnt = 0;
  int          wr_run = 0, wr_len = 0, both_hi = 0;
  logic        wr_prev = 1'b0, rd_prev = 1'b0;
  logic [15:0] rd_vals[$];
  logic [15:0] wr_addrs[$], wr_datas[$], rd_addrs[$];
  logic [7:0]  tx_log[$];

  always @(negedge clk) begin
    bus_ack   = 1'b0;
    bus_rdata = 16'h0;
    if (tx_dv) tx_log.push_back(tx_byte);
    if (bus_wr && bus_rd) both_hi++;
    if (bus_wr && !wr_prev) begin
      wr_addrs.push_back(bus_addr);
      wr_datas.push_back(bus_wdata);
    end
    if (bus_rd && !rd_prev) rd_addrs.push_back(bus_addr);
    if (bus_wr) wr_run++;
    else begin
      if (wr_prev) wr_len = wr_run;
      wr_run = 0;
    end
    wr_prev = bus_wr;
    rd_prev = bus_rd;
    if (bus_wr || bus_rd) begin
      strobe_cnt++;
      if (ack_delay > 0 && strobe_cnt == ack_delay) begin
        bus_ack = 1'b1;
        if (bus_rd && rd_vals.size() > 0) bus_rdata = rd_vals.pop_front();
      end
    end else begin
      strobe_cnt = 0;
    end
  end

  function automatic logic [31:0] at16(input logic [15:0] q[$], input int i);
    return (i < q.size()) ? {16'h0, q[i]} : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] at8(input logic [7:0] q[$], input int i);
    return (i < q.size()) ? {24'h0, q[i]} : 32'hDEAD_BEEF;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
    tick(10);
  endtask

  task automatic frame_begin;
    tx_log.delete();
    wr_addrs.delete();
    wr_datas.delete();
    rd_addrs.delete();
    @(negedge clk);
    cs_n = 1'b0;
    tick(5);
  endtask

  task automatic frame_close;
    @(negedge clk);
    cs_n = 1'b1;
    tick(5);
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    cs_n    = 1'b1;
    tick(3);
    expect_eq("rst_busy",  32'(busy), 0);
    expect_eq("rst_txdv",  32'(tx_dv), 0);
    expect_eq("rst_txb",   32'(tx_byte), 0);
    expect_eq("rst_addr",  32'(bus_addr), 0);
    expect_eq("rst_wdata", 32'(bus_wdata), 0);
    expect_eq("rst_wr",    32'(bus_wr), 0);
    expect_eq("rst_rd",    32'(bus_rd), 0);
    expect_eq("rst_err",   32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);

    // plain write, ack after 3 cycles
    ack_delay = 3;
    frame_begin;
    send_byte(8'h00); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    frame_close;
    expect_eq("w_count", 32'(wr_addrs.size()), 1);
    expect_eq("w_addr",  at16(wr_addrs, 0), 32'h1234);
    expect_eq("w_data",  at16(wr_datas, 0), 32'hABCD);
    expect_eq("w_err",   32'(err), 0);
    expect_eq("w_stat",  at8(tx_log, 0), 32'hA5);
    expect_eq("w_idle",  32'(busy), 0);

    // auto-increment read across the address wrap
    rd_vals = '{16'h1111, 16'h2222};
    frame_begin;
    send_byte(8'hC0); send_byte(8'hFF); send_byte(8'hFF);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    frame_close;
    expect_eq("r_txn",   32'(tx_log.size()), 5);
    expect_eq("r_tx0",   at8(tx_log, 0), 32'hA5);
    expect_eq("r_tx1",   at8(tx_log, 1), 32'h11);
    expect_eq("r_tx2",   at8(tx_log, 2), 32'h11);
    expect_eq("r_tx3",   at8(tx_log, 3), 32'h22);
    expect_eq("r_tx4",   at8(tx_log, 4), 32'h22);
    expect_eq("r_count", 32'(rd_addrs.size()), 2);
    expect_eq("r_addr0", at16(rd_addrs, 0), 32'hFFFF);
    expect_eq("r_addr1", at16(rd_addrs, 1), 32'h0000);
    expect_eq("r_err",   32'(err), 0);

    // write that is never acknowledged
    ack_delay = 0;
    frame_begin;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
    send_byte(8'h55); send_byte(8'hAA);
    tick(TMO + 20);
    expect_eq("t_count", 32'(wr_addrs.size()), 1);
    expect_eq("t_len",   32'(wr_len), TMO);
    expect_eq("t_wr",    32'(bus_wr), 0);
    expect_eq("t_err",   32'(err), 1);
    frame_close;
    expect_eq("t_errhold", 32'(err), 1);

    // illegal command byte
    ack_delay = 3;
    frame_begin;
    send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'h56); send_byte(8'h78);
    expect_eq("c_err", 32'(err), 1);
    expect_eq("c_wr",  32'(wr_addrs.size()), 0);
    expect_eq("c_rd",  32'(rd_addrs.size()), 0);
    frame_close;
    frame_begin;
    expect_eq("c_errclr", 32'(err), 0);
    expect_eq("c_stat",   at8(tx_log, 0), 32'hA5);
    frame_close;

    // frame aborted inside the low data byte
    frame_begin;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h10); send_byte(8'hAB);
    @(negedge clk);
    cs_n = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      n++;
      if (!busy) break;
    end
    expect_eq("a_idle_time", 32'(n <= 4), 1);
    tick(5);
    expect_eq("a_nowrite", 32'(wr_addrs.size()), 0);

    // reset while a read is outstanding
    ack_delay = 0;
    frame_begin;
    send_byte(8'h80); send_byte(8'h00); send_byte(8'h05);
    expect_eq("x_rd_on", 32'(bus_rd), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    expect_eq("x_rd_off", 32'(bus_rd), 0);
    expect_eq("x_busy",   32'(busy), 0);
    cs_n = 1'b1;
    tick(3);
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    ack_delay = 3;
    frame_begin;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    send_byte(8'h12); send_byte(8'h34);
    frame_close;
    expect_eq("x_count", 32'(wr_addrs.size()), 1);
    expect_eq("x_addr",  at16(wr_addrs, 0), 32'h0020);
    expect_eq("x_data",  at16(wr_datas, 0), 32'h1234);
    expect_eq("x_err",   32'(err), 0);

    expect_eq("excl_strobes", 32'(both_hi), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
